dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl_if.sv | 23 ++
 rtl/dmem_ctrl.sv | 122 ++++++++++++
 tb/tb_dmem_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// Processor-side request/response bundle for the data-memory controller.
interface dmem_ctrl_if;
  logic        req;
  logic [31:0] addr;
  logic        write_enable;
  logic        byte_sel;
  logic        half_word;
  logic        sign_extend;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        done;
  logic        err;

  modport master (
    output req, addr, write_enable, byte_sel, half_word, sign_extend, data_in,
    input  data_out, done, err
  );

  modport slave (
    input  req, addr, write_enable, byte_sel, half_word, sign_extend, data_in,
    output data_out, done, err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Big-endian byte/half/word load-store controller in front of a single-port
// SRAM with one-cycle read latency; sub-word stores use read-modify-write.
module dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned AW          = 12
) (
  input  logic          clock,
  input  logic          reset,
  dmem_ctrl_if.slave    bus,
  output logic [AW-1:0] sram_addr,
  output logic          sram_we,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  typedef enum logic [2:0] {
    IDLE, WR, RD, RESP, RMW_RD, RMW_MRG, RMW_WR, ERR
  } state_t;

  state_t        state;
  logic          is_b, is_h, is_w, misaligned;
  logic [1:0]    off;
  logic [7:0]    lane8;
  logic [15:0]   lane16;
  logic [31:0]   load_val, merged;
  logic [AW-1:0] word_idx;

  always_comb begin
    off        = bus.addr[1:0];
    is_b       = bus.byte_sel;
    is_h       = bus.half_word & ~bus.byte_sel;
    is_w       = ~bus.byte_sel & ~bus.half_word;
    misaligned = (is_h & off[0]) | (is_w & (off != 2'b00));
    word_idx   = bus.addr[AW+1:2] & AW'(DEPTH_WORDS - 1);

    case (off)
      2'd0:    lane8 = sram_rdata[31:24];
      2'd1:    lane8 = sram_rdata[23:16];
      2'd2:    lane8 = sram_rdata[15:8];
      default: lane8 = sram_rdata[7:0];
    endcase
    lane16 = off[1] ? sram_rdata[15:0] : sram_rdata[31:16];

    if (is_b)
      load_val = {{24{bus.sign_extend & lane8[7]}}, lane8};
    else if (is_h)
      load_val = {{16{bus.sign_extend & lane16[15]}}, lane16};
    else
      load_val = sram_rdata;

    merged = sram_rdata;
    if (is_b) begin
      case (off)
        2'd0:    merged[31:24] = bus.data_in[7:0];
        2'd1:    merged[23:16] = bus.data_in[7:0];
        2'd2:    merged[15:8]  = bus.data_in[7:0];
        default: merged[7:0]   = bus.data_in[7:0];
      endcase
    end else if (is_h) begin
      if (off[1]) merged[15:0]  = bus.data_in[15:0];
      else        merged[31:16] = bus.data_in[15:0];
    end
  end

  // Request fields are held until done, so later states read them live.
  // sram_wdata doubles as the read-modify-write merge register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      bus.data_out <= '0;
      sram_we      <= 1'b0;
      sram_addr    <= '0;
      sram_wdata   <= '0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      sram_we  <= 1'b0;
      case (state)
        IDLE: begin
          // done still high here means the previous load just finished
          if (bus.req && !bus.done) begin
            sram_addr <= word_idx;
            if (misaligned) begin
              state    <= ERR;
              bus.done <= 1'b1;
              bus.err  <= 1'b1;
            end else if (bus.write_enable) begin
              if (is_w) begin
                state      <= WR;
                sram_we    <= 1'b1;
                sram_wdata <= bus.data_in;
                bus.done   <= 1'b1;
              end else begin
                state <= RMW_RD;
              end
            end else begin
              state <= RD;
            end
          end
        end
        RD:      state <= RESP;
        RESP: begin
          bus.data_out <= load_val;
          bus.done     <= 1'b1;
          state        <= IDLE;
        end
        RMW_RD:  state <= RMW_MRG;
        RMW_MRG: begin
          sram_wdata <= merged;
          sram_we    <= 1'b1;
          bus.done   <= 1'b1;
          state      <= RMW_WR;
        end
        WR, RMW_WR, ERR: state <= IDLE;
        default:         state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: behavioural SRAM, hand-computed expectations.
module tb_dmem_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] sram_addr;
  logic        sram_we;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [31:0] mem [4096];

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;
  int done_cnt = 0;

  dmem_ctrl_if bus ();

  dmem_ctrl #(.DEPTH_WORDS(4096), .AW(12)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus.slave),
    .sram_addr  (sram_addr),
    .sram_we    (sram_we),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (sram_we) begin
      mem[sram_addr] <= sram_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (bus.done) done_cnt <= done_cnt + 1;
    sram_rdata <= mem[sram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  // Issues one access, returns cycles from the sampling edge to done (-1 on timeout).
  task automatic run(input logic w, input logic b, input logic h, input logic se,
                     input logic [31:0] a, input logic [31:0] d, input bit drop,
                     output int lat, output logic e, output int writes);
    int  n;
    int  we0;
    bit  seen;
    @(negedge clock);
    bus.req = 1'b1; bus.write_enable = w; bus.byte_sel = b; bus.half_word = h;
    bus.sign_extend = se; bus.addr = a; bus.data_in = d;
    we0 = we_cnt; n = 0; seen = 1'b0; e = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clock); #1;
      if (drop) bus.req = 1'b0;
      n++;
      if (bus.done) begin seen = 1'b1; e = bus.err; end
    end
    bus.req = 1'b0;
    @(posedge clock); #1;
    writes = we_cnt - we0;
    lat = seen ? n : -1;
  endtask

  int   lat, wr, dc0, we0;
  logic e;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    bus.req = 1'b0; bus.write_enable = 1'b0; bus.byte_sel = 1'b0; bus.half_word = 1'b0;
    bus.sign_extend = 1'b0; bus.addr = '0; bus.data_in = '0;
    #3 reset = 1'b0;
    #2;
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_err", {31'b0, bus.err}, 32'd0);
    check("rst_dout", bus.data_out, 32'd0);
    check("rst_we", {31'b0, sram_we}, 32'd0);
    check("rst_addr", {20'b0, sram_addr}, 32'd0);
    check("rst_wdata", sram_wdata, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    run(1, 0, 0, 0, 32'h10, 32'hDEADBEEF, 0, lat, e, wr);
    check("wst_lat", lat, 1); check("wst_err", {31'b0, e}, 0); check("wst_writes", wr, 1);
    check("wst_mem", mem[4], 32'hDEADBEEF);
    run(0, 0, 0, 0, 32'h10, 32'h0, 0, lat, e, wr);
    check("wld_lat", lat, 3); check("wld_dout", bus.data_out, 32'hDEADBEEF);
    check("wld_writes", wr, 0);

    run(1, 0, 0, 0, 32'h10, 32'h11223344, 0, lat, e, wr);
    run(1, 1, 0, 0, 32'h11, 32'h000000AA, 0, lat, e, wr);
    check("bst_lat", lat, 3); check("bst_writes", wr, 1); check("bst_err", {31'b0, e}, 0);
    check("bst_mem", mem[4], 32'h11AA3344);
    run(0, 1, 0, 1, 32'h11, 32'h0, 0, lat, e, wr);
    check("bld_sx_lat", lat, 3); check("bld_sx", bus.data_out, 32'hFFFFFFAA);
    run(0, 1, 0, 0, 32'h11, 32'h0, 0, lat, e, wr);
    check("bld_zx", bus.data_out, 32'h000000AA);

    run(1, 0, 0, 0, 32'h10, 32'h11AA8344, 0, lat, e, wr);
    run(0, 0, 1, 1, 32'h12, 32'h0, 0, lat, e, wr);
    check("hld_sx", bus.data_out, 32'hFFFF8344);
    run(1, 0, 1, 0, 32'h10, 32'h00001234, 0, lat, e, wr);
    check("hst_lat", lat, 3); check("hst_mem", mem[4], 32'h12348344);
    run(0, 0, 1, 0, 32'h10, 32'h0, 0, lat, e, wr);
    check("hld_zx", bus.data_out, 32'h00001234);
    run(1, 1, 0, 0, 32'h13, 32'hFFFFFF99, 0, lat, e, wr);
    check("bst3_mem", mem[4], 32'h12348399);
    run(0, 1, 1, 1, 32'h12, 32'h0, 0, lat, e, wr);
    check("byte_wins", bus.data_out, 32'hFFFFFF83);
    run(0, 0, 0, 1, 32'h10, 32'h0, 0, lat, e, wr);
    check("wld_se_ign", bus.data_out, 32'h12348399);

    run(0, 0, 0, 0, 32'h13, 32'h0, 0, lat, e, wr);
    check("mis_w_lat", lat, 1); check("mis_w_err", {31'b0, e}, 1);
    check("mis_w_writes", wr, 0); check("mis_w_dout", bus.data_out, 32'h12348399);
    run(0, 0, 1, 0, 32'h11, 32'h0, 0, lat, e, wr);
    check("mis_h_lat", lat, 1); check("mis_h_err", {31'b0, e}, 1);
    check("mis_h_dout", bus.data_out, 32'h12348399);
    run(1, 0, 0, 0, 32'h12, 32'h0, 0, lat, e, wr);
    check("mis_st_err", {31'b0, e}, 1); check("mis_st_writes", wr, 0);
    check("mis_st_mem", mem[4], 32'h12348399);

    run(1, 0, 0, 0, 32'h00004010, 32'hCAFEF00D, 0, lat, e, wr);
    check("wrap_mem", mem[4], 32'hCAFEF00D);
    run(0, 0, 0, 0, 32'h10, 32'h0, 1, lat, e, wr);
    check("drop_lat", lat, 3); check("drop_dout", bus.data_out, 32'hCAFEF00D);

    run(1, 0, 0, 0, 32'h14, 32'h55667788, 0, lat, e, wr);
    @(negedge clock);
    bus.req = 1'b1; bus.write_enable = 1'b1; bus.byte_sel = 1'b1; bus.half_word = 1'b0;
    bus.sign_extend = 1'b0; bus.addr = 32'h15; bus.data_in = 32'h000000EE;
    we0 = we_cnt; dc0 = done_cnt;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("arst_done", {31'b0, bus.done}, 0); check("arst_dout", bus.data_out, 0);
    check("arst_we", {31'b0, sram_we}, 0); check("arst_addr", {20'b0, sram_addr}, 0);
    check("arst_wdata", sram_wdata, 0);
    repeat (3) @(posedge clock);
    #1;
    check("arst_writes", we_cnt - we0, 0); check("arst_dones", done_cnt - dc0, 0);
    check("arst_mem", mem[5], 32'h55667788);
    bus.req = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    run(0, 0, 0, 0, 32'h14, 32'h0, 0, lat, e, wr);
    check("post_rst_lat", lat, 3); check("post_rst_dout", bus.data_out, 32'h55667788);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
